acq_fifo_arbiter: RTL and testbench

ACQ_FIFO_ARBITER -- requirements
Module: acq_fifo_arbiter

---
 rtl/acq_fifo_arbiter_pkg.sv | 19 +
 rtl/readout_timer.sv | 39 +++
 rtl/acq_fifo_arbiter.sv | 116 +++++++++++
 tb/tb_acq_fifo_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_fifo_arbiter_pkg.sv
// Shared acquisition definitions: event word width, timer width and
// one-hot arbiter state encoding used by the channel controllers.
package acq_fifo_arbiter_pkg;

    localparam int EVENT_WIDTH = 32;
    localparam int TIMER_WIDTH = 24;

    localparam int ST_IDLE    = 0;
    localparam int ST_PUSH    = 1;
    localparam int ST_READOUT = 2;
    localparam int ST_SPARE   = 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_PUSH    = 4'b0010,
        S_READOUT = 4'b0100
    } state_t;

endpackage

// File: rtl/readout_timer.sv
// Saturating readout timer with clear, enable and terminal-count pulse.
// LIMIT of zero disables the terminal count.
module readout_timer
    import acq_fifo_arbiter_pkg::*;
#(
    parameter logic [TIMER_WIDTH-1:0] LIMIT = 24'd4000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [TIMER_WIDTH-1:0] LAST = LIMIT - 24'd1;
    localparam logic [TIMER_WIDTH-1:0] SAT  = '1;

    logic [TIMER_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && count_q != SAT) begin
            count_d = count_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = enable_i && (LIMIT != '0) && (count_q == LAST);

endmodule

// File: rtl/acq_fifo_arbiter.sv
// Round-robin arbiter between the sync and async acquisition controllers
// feeding the event FIFO, with readout_done routing and readout timeout.
module acq_fifo_arbiter
    import acq_fifo_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = EVENT_WIDTH,
    parameter logic [TIMER_WIDTH-1:0] TIMEOUT = 24'd4000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  fifo_valid,
    output logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_ready,
    input  logic                  readout_done,
    output logic                  readout_done0,
    output logic                  readout_done1,
    output logic                  timeout_err,
    output logic                  owner,
    output logic [3:0]            state
);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  tmo_q, tmo_d;
    logic                  gnt0, gnt1;
    logic                  tmr_clear, tmr_tc;

    // On a tie the requester that did not own the last grant wins
    always_comb begin
        gnt0 = state_q[ST_IDLE] && req0_valid && (!req1_valid || owner_q);
        gnt1 = state_q[ST_IDLE] && req1_valid && (!req0_valid || !owner_q);
    end

    assign req0_ready = reset_n && gnt0;
    assign req1_ready = reset_n && gnt1;
    assign tmr_clear  = state_q[ST_PUSH] && fifo_ready;

    readout_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (tmr_clear),
        .enable_i(state_q[ST_READOUT]),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = data_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        tmo_d   = 1'b0;
        unique case (1'b1)
            state_q[ST_IDLE]: begin
                if (gnt0 || gnt1) begin
                    state_d = S_PUSH;
                    owner_d = gnt1;
                    data_d  = gnt1 ? req1_data : req0_data;
                end
            end
            state_q[ST_PUSH]: begin
                if (fifo_ready) state_d = S_READOUT;
            end
            state_q[ST_READOUT]: begin
                // readout_done takes priority over a coincident timeout
                if (readout_done) begin
                    state_d = S_IDLE;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                end else if (tmr_tc) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b1;
            data_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            tmo_q   <= tmo_d;
        end
    end

    assign fifo_valid    = state_q[ST_PUSH];
    assign fifo_data     = data_q;
    assign readout_done0 = done0_q;
    assign readout_done1 = done1_q;
    assign timeout_err   = tmo_q;
    assign owner         = owner_q;
    assign state         = state_q;

endmodule

// File: tb/tb_acq_fifo_arbiter.sv
// Directed testbench for acq_fifo_arbiter (TIMEOUT=16 instance plus
// a TIMEOUT=0 instance for the disabled-timeout case).
module tb_acq_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid, fifo_ready, readout_done;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, fifo_valid;
    logic [31:0] fifo_data;
    logic        readout_done0, readout_done1, timeout_err, owner;
    logic [3:0]  state;

    logic        n_req0_valid, n_req1_valid, n_fifo_ready, n_readout_done;
    logic [31:0] n_req0_data, n_req1_data;
    logic        n_req0_ready, n_req1_ready, n_fifo_valid;
    logic [31:0] n_fifo_data;
    logic        n_done0, n_done1, n_timeout_err, n_owner;
    logic [3:0]  n_state;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (fifo_valid && fifo_ready) wr_cnt <= wr_cnt + 1;

    acq_fifo_arbiter #(.DATA_WIDTH(32), .TIMEOUT(24'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
        .readout_done(readout_done), .readout_done0(readout_done0),
        .readout_done1(readout_done1), .timeout_err(timeout_err),
        .owner(owner), .state(state)
    );

    acq_fifo_arbiter #(.DATA_WIDTH(32), .TIMEOUT(24'd0)) dut_nt (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(n_req0_valid), .req0_data(n_req0_data), .req0_ready(n_req0_ready),
        .req1_valid(n_req1_valid), .req1_data(n_req1_data), .req1_ready(n_req1_ready),
        .fifo_valid(n_fifo_valid), .fifo_data(n_fifo_data), .fifo_ready(n_fifo_ready),
        .readout_done(n_readout_done), .readout_done0(n_done0),
        .readout_done1(n_done1), .timeout_err(n_timeout_err),
        .owner(n_owner), .state(n_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'h0; req1_data = 32'h0;
        fifo_ready = 1'b0; readout_done = 1'b0;
        n_req0_valid = 1'b0; n_req1_valid = 1'b0;
        n_req0_data = 32'h0; n_req1_data = 32'h0;
        n_fifo_ready = 1'b0; n_readout_done = 1'b0;
        #3;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        repeat (2) tick();
        n_checks++;
        if (state !== 4'b0001 || fifo_valid !== 1'b0 || fifo_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: state %b fv %b fd %h expected 0001 0 0", state, fifo_valid, fifo_data);
        end
        n_checks++;
        if ({owner, readout_done0, readout_done1, timeout_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 1000", {owner, readout_done0, readout_done1, timeout_err});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_tie_and_routing();
        req0_valid = 1'b1; req0_data = 32'hA;
        req1_valid = 1'b1; req1_data = 32'hB;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'b0010 || fifo_valid !== 1'b1 || fifo_data !== 32'hA || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_push0: state %b fv %b fd %h own %b expected 0010 1 a 0", state, fifo_valid, fifo_data, owner);
        end
        n_checks++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL push_ready1: got %b expected 0", req1_ready);
        end
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b0;
        n_checks++;
        if (state !== 4'b0100 || fifo_valid !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_readout: state %b fv %b r1 %b expected 0100 0 0", state, fifo_valid, req1_ready);
        end
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        #1;
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b10 || state !== 4'b0001 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_done0: done %b state %b r1 %b expected 10 0001 1",
                     {readout_done0, readout_done1}, state, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_checks++;
        if (fifo_data !== 32'hB || owner !== 1'b1 || fifo_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_push1: fd %h own %b fv %b expected b 1 1", fifo_data, owner, fifo_valid);
        end
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b0;
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b01) begin
            n_fail++;
            $display("FAIL route1: got %b expected 01", {readout_done0, readout_done1});
        end
        tick();
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL route1_width: got %b expected 00", {readout_done0, readout_done1});
        end
    endtask

    task automatic test_backpressure();
        int start_wr;
        start_wr = wr_cnt;
        req0_valid = 1'b1; req0_data = 32'h1234_5678;
        tick();
        req0_valid = 1'b0;
        req0_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (fifo_valid !== 1'b1 || fifo_data !== 32'h1234_5678) begin
                n_fail++;
                $display("FAIL bp_hold%0d: fv %b fd %h expected 1 12345678", i, fifo_valid, fifo_data);
            end
            tick();
        end
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b1;
        tick();
        tick();
        fifo_ready = 1'b0;
        n_checks++;
        if (wr_cnt - start_wr !== 1 || state !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_writes: got %0d state %b expected 1 0100", wr_cnt - start_wr, state);
        end
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_done: got %b expected 10", {readout_done0, readout_done1});
        end
        tick();
    endtask

    task automatic test_timeout();
        req1_valid = 1'b1; req1_data = 32'h55;
        tick();
        req1_valid = 1'b0;
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (state !== 4'b0100 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_wait%0d: state %b err %b expected 0100 0", i, state, timeout_err);
            end
            tick();
        end
        n_checks++;
        if (timeout_err !== 1'b1 || state !== 4'b0001 || {readout_done0, readout_done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_pulse: err %b state %b done %b expected 1 0001 00",
                     timeout_err, state, {readout_done0, readout_done1});
        end
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_width: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_simultaneous_and_stray();
        req0_valid = 1'b1; req0_data = 32'h77;
        tick();
        req0_valid = 1'b0;
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b0;
        repeat (15) tick();
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b10 || timeout_err !== 1'b0 || state !== 4'b0001) begin
            n_fail++;
            $display("FAIL simul: done %b err %b state %b expected 10 0 0001",
                     {readout_done0, readout_done1}, timeout_err, state);
        end
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_err: got %b expected 0", timeout_err);
        end
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        n_checks++;
        if ({readout_done0, readout_done1, timeout_err} !== 3'b000 || state !== 4'b0001) begin
            n_fail++;
            $display("FAIL stray: outs %b state %b expected 000 0001",
                     {readout_done0, readout_done1, timeout_err}, state);
        end
        tick();
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_late: got %b expected 00", {readout_done0, readout_done1});
        end
    endtask

    task automatic test_no_timeout();
        n_req0_valid = 1'b1; n_req0_data = 32'h99;
        tick();
        n_req0_valid = 1'b0;
        n_fifo_ready = 1'b1;
        tick();
        n_fifo_ready = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (n_state !== 4'b0100 || n_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nt_wait: state %b err %b expected 0100 0", n_state, n_timeout_err);
        end
        n_readout_done = 1'b1;
        tick();
        n_readout_done = 1'b0;
        n_checks++;
        if ({n_done0, n_done1} !== 2'b10 || n_state !== 4'b0001) begin
            n_fail++;
            $display("FAIL nt_done: done %b state %b expected 10 0001", {n_done0, n_done1}, n_state);
        end
    endtask

    task automatic test_reset_mid_readout();
        int start_wr;
        req1_valid = 1'b1; req1_data = 32'hC1;
        tick();
        req1_valid = 1'b0;
        fifo_ready = 1'b1;
        tick();
        fifo_ready = 1'b0;
        reset_n = 1'b0;
        readout_done = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'b0001 || fifo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: state %b fv %b expected 0001 0", state, fifo_valid);
        end
        tick();
        reset_n = 1'b1;
        readout_done = 1'b0;
        tick();
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b00 || owner !== 1'b1 || state !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid: done %b own %b state %b expected 00 1 0001",
                     {readout_done0, readout_done1}, owner, state);
        end
        start_wr = wr_cnt;
        req0_valid = 1'b1; req0_data = 32'hE0;
        req1_valid = 1'b1; req1_data = 32'hE1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_regrant: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        fifo_ready = 1'b1;
        n_checks++;
        if (fifo_data !== 32'hE0 || state !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_push: fd %h state %b expected e0 0010", fifo_data, state);
        end
        tick();
        fifo_ready = 1'b0;
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        n_checks++;
        if ({readout_done0, readout_done1} !== 2'b10 || wr_cnt - start_wr !== 1) begin
            n_fail++;
            $display("FAIL rst_finish: done %b writes %0d expected 10 1",
                     {readout_done0, readout_done1}, wr_cnt - start_wr);
        end
        n_checks++;
        if (state[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL spare_bit: got %b expected 0", state[3]);
        end
    endtask

    initial begin
        test_reset();
        test_tie_and_routing();
        test_backpressure();
        test_timeout();
        test_simultaneous_and_stray();
        test_no_timeout();
        test_reset_mid_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
